// File: rtl/multi_cycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32 control FSM: states, ALU selects, opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multi_cycle_control_fsm_pkg;

    // Controller states, 3-bit encoded; values 6 and 7 are unused.
    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    // alu_op encodings
    localparam logic [1:0] ALU_OP_ADD    = 2'd0;
    localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'd2;

    // alu_src_b encodings
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    // True for opcodes that need an execute step; everything else except
    // ECALL retires straight out of decode as a NOP.
    function automatic logic needs_ex(input logic [6:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_next_state.sv
// Next-state logic for the multi-cycle control FSM (purely combinational).
// Latency: 0 cycles; the state register lives in the top module.
// Backpressure: IF and MEM hold their state while mem_ready is low.
// Ports: state/opcode/mem_ready/halt_req in, state_nxt out.
module mc_next_state
    import multi_cycle_control_fsm_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       halt_req,
    output state_t     state_nxt
);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IF: begin
                if (mem_ready) state_nxt = ST_ID;
            end
            ST_ID: begin
                if (opcode == OP_ECALL)  state_nxt = halt_req ? ST_HALT : ST_IF;
                else if (needs_ex(opcode)) state_nxt = ST_EX;
                else                     state_nxt = ST_IF;
            end
            ST_EX: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_nxt = ST_MEM;
                    OP_BRANCH:         state_nxt = ST_IF;
                    default:           state_nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) state_nxt = (opcode == OP_LOAD) ? ST_WB : ST_IF;
            end
            ST_WB:   state_nxt = ST_IF;
            ST_HALT: state_nxt = ST_HALT;
            // Unused encodings recover to fetch.
            default: state_nxt = ST_IF;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// Multi-cycle RV32 controller: state register, control decode, retire counter.
// Latency: BRANCH 3, ALU/STORE/JAL/JALR 4, LOAD 5 cycles with mem_ready held high.
// Backpressure: each mem_ready=0 cycle in IF or MEM stretches the instruction by one.
// Ports: clk, reset (sync, active-low); opcode/mem_ready/halt_req/bcond in;
//        datapath control strobes, is_halted, inst_retired pulse, instret count out.
module multi_cycle_control_fsm
    import multi_cycle_control_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic        halt_req,
    input  logic        bcond,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_source,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        pc_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        is_halted,
    output logic        inst_retired,
    output logic [31:0] instret
);

    state_t state;
    state_t state_nxt;
    logic   retire;

    // The branch condition is combined with pc_write_cond in the datapath's
    // PC-enable logic, so the controller never needs to look at it.
    logic unused_bcond;
    assign unused_bcond = bcond;

    mc_next_state u_next_state (
        .state     (state),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .halt_req  (halt_req),
        .state_nxt (state_nxt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IF;
            instret <= 32'd0;
        end else begin
            state <= state_nxt;
            if (retire) instret <= instret + 32'd1;
        end
    end

    // Every path back to fetch from a later state is the last cycle of an
    // instruction; IF->IF is only a fetch stall and HALT never leaves.
    assign retire       = reset && (state != ST_IF) && (state_nxt == ST_IF);
    assign inst_retired = retire;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        pc_to_reg     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_RS2;
        alu_op        = ALU_OP_ADD;
        is_halted     = 1'b0;

        // Everything stays quiet while reset is held.
        if (reset) begin
            case (state)
                ST_IF: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    // IR load and PC <- PC+4 only when the fetch completes.
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                ST_ID: begin
                    // Speculative branch target PC+imm lands in ALUOut.
                    alu_src_b = SRC_B_IMM;
                end
                ST_EX: begin
                    case (opcode)
                        OP_ARITH: begin
                            alu_src_a = 1'b1;
                            alu_op    = ALU_OP_FUNCT;
                        end
                        OP_ARITH_IMM: begin
                            alu_src_a = 1'b1;
                            alu_src_b = SRC_B_IMM;
                            alu_op    = ALU_OP_FUNCT;
                        end
                        OP_LOAD, OP_STORE, OP_JALR: begin
                            alu_src_a = 1'b1;
                            alu_src_b = SRC_B_IMM;
                        end
                        OP_BRANCH: begin
                            alu_src_a     = 1'b1;
                            alu_op        = ALU_OP_BRANCH;
                            pc_write_cond = 1'b1;
                            pc_source     = 1'b1;
                        end
                        OP_JAL: begin
                            // PC operand is the pre-increment PC kept by the datapath.
                            alu_src_b = SRC_B_IMM;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (opcode == OP_LOAD);
                    mem_write = (opcode == OP_STORE);
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opcode == OP_LOAD);
                    if (opcode == OP_JAL || opcode == OP_JALR) begin
                        pc_to_reg = 1'b1;
                        pc_write  = 1'b1;
                        pc_source = 1'b1;
                    end
                end
                ST_HALT: is_halted = 1'b1;
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/multi_cycle_control_fsm.md
MULTI_CYCLE_CONTROL_FSM -- requirements
Module: multi_cycle_control_fsm

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  single system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low (0 = reset), sampled on rising clk
- opcode  in  7  IR[6:0]; valid from state ID onward; encodings per shared opcodes.v
- mem_ready  in  1  memory handshake; access completes in the cycle it is 1
- halt_req  in  1  ECALL halt condition from datapath (x17 == 10)
- bcond  in  1  branch-taken flag from ALU
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by bcond
- pc_source  out  1  0 = live ALU result, 1 = ALUOut register
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register writeback from MDR
- pc_to_reg  out  1  register writeback from PC (JAL/JALR link)
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = rs1
- alu_src_b  out  2  0 = rs2, 1 = constant 4, 2 = immediate
- alu_op  out  2  0 = add, 1 = branch compare, 2 = funct-decoded
- is_halted  out  1  processor halted
- inst_retired  out  1  one-cycle pulse per completed instruction
- instret  out  32  retired-instruction count

Function
REQ-002 The FSM SHALL have states IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, 3-bit encoded. All control outputs SHALL be Moore outputs decoded from the current state and opcode.
REQ-003 IF:
- Asserts mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0.
- Holds while mem_ready=0.
- When mem_ready=1: asserts ir_write=1 and pc_write=1 with pc_source=0 (PC <- PC+4), then moves to ID.
REQ-004 ID: alu_src_a=0, alu_src_b=2, alu_op=0. Next state by opcode:
- ECALL with halt_req=1 -> HALT.
- ECALL with halt_req=0 -> IF, with a retire pulse.
- ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JAL, JALR -> EX.
- Any other opcode -> IF as a NOP, with a retire pulse.
REQ-005 EX:
- ARITHMETIC: alu_src_a=1, alu_src_b=0, alu_op=2; -> WB.
- ARITHMETIC_IMM: alu_src_a=1, alu_src_b=2, alu_op=2; -> WB.
- LOAD/STORE: alu_src_a=1, alu_src_b=2, alu_op=0; -> MEM.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1; -> IF, with a retire pulse.
- JAL: alu_src_a=0, alu_src_b=2, alu_op=0; -> WB. The PC operand is the pre-increment PC held by the datapath.
- JALR: alu_src_a=1, alu_src_b=2, alu_op=0; -> WB.
REQ-006 MEM:
- i_or_d=1; mem_read=1 for LOAD, mem_write=1 for STORE.
- Holds while mem_ready=0, with requests held asserted.
- On mem_ready=1: LOAD -> WB; STORE -> IF with a retire pulse.
REQ-007 WB:
- Asserts reg_write=1.
- LOAD: mem_to_reg=1.
- JAL/JALR: pc_to_reg=1, pc_write=1, pc_source=1.
- Always -> IF, with a retire pulse.
REQ-008 HALT SHALL be absorbing until reset. It asserts is_halted=1 and deasserts every write/request output.
REQ-009 inst_retired SHALL be 1 exactly in the final cycle of each instruction. In that same cycle instret SHALL increment by 1, wrapping from 0xFFFFFFFF to 0.
REQ-010 Minimum latencies with mem_ready held at 1:
- BRANCH: 3 cycles.
- ARITHMETIC, ARITHMETIC_IMM, STORE, JAL, JALR: 4 cycles.
- LOAD: 5 cycles.
- Each mem_ready=0 cycle in IF or MEM adds one cycle.
REQ-011 In any state where a write-enable or memory-request output is not listed as asserted, it SHALL be 0.

Reset
REQ-012 With reset=0 at a rising edge:
- State SHALL become IF and instret SHALL become 0.
- Reset SHALL take priority over every transition, including mid-MEM wait and HALT.
REQ-013 While reset=0, all control outputs SHALL be 0, as SHALL is_halted and inst_retired; outputs become valid from the first cycle after reset returns to 1.

Structure
REQ-014 State encodings and the alu_op/alu_src_b encodings SHALL live in a shared header alongside opcodes.v. Opcodes SHALL come only from opcodes.v.
REQ-015 Next-state logic SHALL be one sub-module, mc_next_state. Output decode and instret SHALL live in the top module.

Verification
REQ-016 A bench SHALL cover these directed scenarios:
- ARITHMETIC opcode, mem_ready=1 -> states IF,ID,EX,WB; reg_write=1 only in WB; one inst_retired pulse; instret 0->1.
- LOAD with mem_ready=0 for 2 cycles in MEM -> 7 cycles total; mem_read and i_or_d=1 held throughout MEM; mem_to_reg=1 in WB.
- BRANCH with bcond=1 -> pc_write_cond=1, pc_source=1 in EX; returns to IF after 3 cycles.
- ECALL with halt_req=1 -> HALT after 2 cycles; is_halted=1 and no writes for 10+ cycles; reset=0 -> IF with instret=0.
- reset=0 asserted during a MEM wait -> next state IF, mem_write=0, no retire pulse.
- instret preset near 0xFFFFFFFF via retiring instructions -> wraps to 0 on the next retire.
